bf_phase_sequencer: RTL and testbench

Run-control and phase sequencer for the Brainfuck core datapath. It replaces the free-running three-phase clock ring with single-cycle enable strobes in the fast clock domain: RAM read, decode, then RAM write. Strobes are paced by a programmable divider. The block adds run/step/halt control, a program-counter breakpoint, sticky stop on ROM overrun, and an executed-instruction counter. It sits between the board clock and the core/RAM/SFR write path.

---
 rtl/bf_phase_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_bf_phase_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_phase_sequencer.sv
// bf_phase_sequencer
//   Run-control and phase sequencer for the Brainfuck core datapath. It turns
//   the board clock into single-cycle enable strobes (RAM read, decode, RAM
//   write) paced by a programmable divider. It also adds run/step/halt
//   control, a PC breakpoint, a sticky stop on ROM overrun and an
//   executed-instruction counter.
//
// Ports
//   clk          board clock, rising edge
//   nrst         asynchronous active-low reset
//   div_value    phase period N in clk cycles (0 behaves as 1)
//   run_req      pulse: start free-running execution (IDLE only)
//   step_req     pulse: execute exactly one instruction (IDLE only)
//   halt_req     pulse: stop at the next instruction boundary
//   finish       ROM overrun from the ROM decoder
//   pc           current ROM address from the core
//   bp_enable    breakpoint enable
//   bp_addr      breakpoint address
//   ph_read      one-cycle RAM read strobe
//   ph_decode    one-cycle core execute strobe
//   ph_write     one-cycle RAM write / address load / SFR write strobe
//   ram_wre      RAM write-enable window (cycle after ph_decode through ph_write)
//   running      high in RUN or STEP
//   done         sticky program-finished flag
//   bp_hit       high while parked in IDLE because of the breakpoint
//   instr_count  completed-instruction counter (wraps)
//
// Every output comes straight from a flop. The flops are loaded from the
// next-state values, so an output describes the same cycle as the state
// registers. That is how run_req in cycle t can give ph_read at t+N.
module bf_phase_sequencer #(
  parameter int DIV_WIDTH = 16,
  parameter int ROM_AW    = 11
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 halt_req,
  input  logic                 finish,
  input  logic [ROM_AW-1:0]    pc,
  input  logic                 bp_enable,
  input  logic [ROM_AW-1:0]    bp_addr,
  output logic                 ph_read,
  output logic                 ph_decode,
  output logic                 ph_write,
  output logic                 ram_wre,
  output logic                 running,
  output logic                 done,
  output logic                 bp_hit,
  output logic [15:0]          instr_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STEP, ST_DONE} state_e;
  typedef enum logic [1:0] {PH_READ, PH_DECODE, PH_WRITE}      phase_e;

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  state_e               state_q, state_d;
  phase_e               phase_q, phase_d;
  logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;    // position inside the current phase period
  logic [DIV_WIDTH-1:0] per_q,   per_d;    // period latched at the last reload, never 0
  logic                 halt_q,  halt_d;   // halt requested, waiting for a boundary
  logic                 first_q, first_d;  // no boundary seen yet since leaving IDLE
  logic                 bp_hit_q, bp_hit_d;

  logic                 rd_q,   rd_d;
  logic                 dec_q,  dec_d;
  logic                 wr_q,   wr_d;
  logic                 wre_q,  wre_d;
  logic                 run_q,  run_d;
  logic                 done_q, done_d;
  logic [15:0]          icnt_q;

  logic [DIV_WIDTH-1:0] div_eff;
  logic                 active_q, active_d;
  logic                 tick;
  logic                 bp_match;
  logic                 last_cnt_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    halt_d   = halt_q;
    first_d  = first_q;
    bp_hit_d = bp_hit_q;

    div_eff  = (div_value == '0) ? ONE : div_value;
    active_q = (state_q == ST_RUN) || (state_q == ST_STEP);
    tick     = active_q && (cnt_q == per_q - ONE);
    // The compare is masked on the first boundary so a run can restart from
    // the breakpoint address without trapping on it again.
    bp_match = bp_enable && (pc == bp_addr) && !first_q;

    case (state_q)
      ST_IDLE: begin
        phase_d = PH_READ;
        cnt_d   = '0;
        halt_d  = 1'b0;
        // A request paired with halt_req in the same cycle is dropped.
        if (!halt_req && (run_req || step_req)) begin
          bp_hit_d = 1'b0;
          first_d  = 1'b1;
          per_d    = div_eff;
          if (finish)       state_d = ST_DONE;
          else if (run_req) state_d = ST_RUN;
          else              state_d = ST_STEP;
        end
      end

      ST_RUN, ST_STEP: begin
        if (state_q == ST_RUN && halt_req) halt_d = 1'b1;
        if (!tick) begin
          cnt_d = cnt_q + ONE;
        end else begin
          // Reload: the next period uses div_value as seen right now.
          cnt_d = '0;
          per_d = div_eff;
          case (phase_q)
            PH_READ:   phase_d = PH_DECODE;
            PH_DECODE: phase_d = PH_WRITE;
            default: begin
              // Instruction boundary: this cycle carries ph_write.
              phase_d = PH_READ;
              first_d = 1'b0;
              if (finish) begin
                state_d = ST_DONE;
              end else if (state_q == ST_STEP) begin
                state_d = ST_IDLE;
              end else if (halt_q || halt_req) begin
                state_d = ST_IDLE;
              end else if (bp_match) begin
                state_d  = ST_IDLE;
                bp_hit_d = 1'b1;
              end
            end
          endcase
        end
      end

      default: begin  // ST_DONE: parked until reset
        phase_d = PH_READ;
        cnt_d   = '0;
        halt_d  = 1'b0;
      end
    endcase

    if (state_d == ST_IDLE || state_d == ST_DONE) halt_d = 1'b0;

    // Output values for the cycle that state_d describes.
    active_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
    last_cnt_d = (cnt_d == per_d - ONE);
    rd_d       = active_d && last_cnt_d && (phase_d == PH_READ);
    dec_d      = active_d && last_cnt_d && (phase_d == PH_DECODE);
    wr_d       = active_d && last_cnt_d && (phase_d == PH_WRITE);
    // The write window covers the whole WRITE phase, starting the cycle after
    // ph_decode and ending with ph_write.
    wre_d      = active_d && (phase_d == PH_WRITE);
    run_d      = active_d;
    done_d     = (state_d == ST_DONE);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_READ;
      cnt_q    <= '0;
      per_q    <= ONE;
      halt_q   <= 1'b0;
      first_q  <= 1'b0;
      bp_hit_q <= 1'b0;
      rd_q     <= 1'b0;
      dec_q    <= 1'b0;
      wr_q     <= 1'b0;
      wre_q    <= 1'b0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      icnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      halt_q   <= halt_d;
      first_q  <= first_d;
      bp_hit_q <= bp_hit_d;
      rd_q     <= rd_d;
      dec_q    <= dec_d;
      wr_q     <= wr_d;
      wre_q    <= wre_d;
      run_q    <= run_d;
      done_q   <= done_d;
      // Counts the instruction in the cycle after its ph_write.
      icnt_q   <= icnt_q + 16'(wr_q);
    end
  end

  assign ph_read     = rd_q;
  assign ph_decode   = dec_q;
  assign ph_write    = wr_q;
  assign ram_wre     = wre_q;
  assign running     = run_q;
  assign done        = done_q;
  assign bp_hit      = bp_hit_q;
  assign instr_count = icnt_q;

endmodule

// File: tb/tb_bf_phase_sequencer.sv
// Testbench for bf_phase_sequencer: directed scenarios plus randomized
// episodes. An event-time reference model predicts each cycle's status and
// every strobe. A separate monitor compares them against the DUT.
module tb_bf_phase_sequencer;
  localparam int DW = 16;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [DW-1:0] div_value;
  logic          run_req, step_req, halt_req, finish, bp_enable;
  logic [AW-1:0] pc, bp_addr;
  logic          ph_read, ph_decode, ph_write, ram_wre, running, done, bp_hit;
  logic [15:0]   instr_count;

  bf_phase_sequencer #(.DIV_WIDTH(DW), .ROM_AW(AW)) dut (
    .clk(clk), .nrst(nrst), .div_value(div_value),
    .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .finish(finish), .pc(pc), .bp_enable(bp_enable), .bp_addr(bp_addr),
    .ph_read(ph_read), .ph_decode(ph_decode), .ph_write(ph_write),
    .ram_wre(ram_wre), .running(running), .done(done), .bp_hit(bp_hit),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit run; bit dn; bit bp; bit wre; int ic; } stat_t;
  typedef struct { int cyc; int kind; } evt_t;   // kind 0=read 1=decode 2=write

  stat_t sq[$];
  evt_t  eq[$];
  int    nvec = 0;
  int    nbad = 0;
  bit    mon_en = 1'b0;

  // Reference model. It tracks the absolute cycle of the next strobe rather
  // than a divider count. Variables describe the current cycle.
  bit m_act, m_step, m_done, m_bp, m_halt, m_first;
  int m_ph, m_next, m_ic;

  function automatic int eff(logic [DW-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic push_status(int k);
    stat_t s;
    s.cyc = k; s.run = m_act; s.dn = m_done; s.bp = m_bp;
    s.wre = m_act && (m_ph == 2); s.ic = m_ic;
    sq.push_back(s);
  endtask

  task automatic model_reset();
    m_act = 0; m_step = 0; m_done = 0; m_bp = 0; m_halt = 0; m_first = 0;
    m_ph = 0; m_next = 0; m_ic = 0;
  endtask

  // Advance the model from cycle k to k+1 using the inputs of cycle k.
  task automatic model_step(int k);
    bit   fire, stop;
    evt_t e;
    fire = m_act && (k == m_next);
    if (fire && m_ph == 2) m_ic = (m_ic + 1) % 65536;
    if (m_done) begin
    end else if (!m_act) begin
      if (!halt_req && (run_req || step_req)) begin
        m_bp = 0; m_first = 1; m_halt = 0;
        if (finish) m_done = 1;
        else begin
          m_act = 1; m_step = !run_req; m_ph = 0; m_next = k + eff(div_value);
        end
      end
    end else begin
      if (halt_req) m_halt = 1;
      if (fire) begin
        if (m_ph < 2) begin
          m_ph = m_ph + 1;
          m_next = k + eff(div_value);
        end else begin
          stop = 1;
          if (finish) m_done = 1;
          else if (m_step || m_halt) begin end
          else if (bp_enable && pc == bp_addr && !m_first) m_bp = 1;
          else stop = 0;
          m_first = 0; m_ph = 0;
          if (stop) begin m_act = 0; m_halt = 0; end
          else m_next = k + eff(div_value);
        end
      end
    end
    push_status(k + 1);
    if (m_act && m_next == k + 1) begin
      e.cyc = k + 1; e.kind = m_ph; eq.push_back(e);
    end
  endtask

  // Monitor: status every cycle, strobe events whenever the DUT fires one.
  stat_t ms;
  evt_t  me;
  int    mkind;
  always @(negedge clk) begin
    if (mon_en && nrst) begin
      nvec++;
      if (sq.size() == 0) begin
        nbad++; $display("FAIL status_underflow cyc=%0d", cyc);
      end else begin
        ms = sq.pop_front();
        if (ms.cyc != cyc || running !== ms.run || done !== ms.dn || bp_hit !== ms.bp ||
            ram_wre !== ms.wre || int'(instr_count) != ms.ic) begin
          nbad++;
          $display("FAIL status cyc=%0d tag=%0d got run=%b done=%b bp=%b wre=%b ic=%0d want run=%b done=%b bp=%b wre=%b ic=%0d",
                   cyc, ms.cyc, running, done, bp_hit, ram_wre, instr_count,
                   ms.run, ms.dn, ms.bp, ms.wre, ms.ic);
        end
      end
      if (ph_read || ph_decode || ph_write) begin
        nvec++;
        mkind = ph_read ? 0 : (ph_decode ? 1 : 2);
        if (eq.size() == 0) begin
          nbad++; $display("FAIL strobe_unexpected cyc=%0d got kind=%0d want none", cyc, mkind);
        end else begin
          me = eq.pop_front();
          if (me.cyc != cyc || me.kind != mkind || $countones({ph_read, ph_decode, ph_write}) != 1) begin
            nbad++;
            $display("FAIL strobe cyc=%0d got kind=%0d rdw=%b%b%b want cyc=%0d kind=%0d",
                     cyc, mkind, ph_read, ph_decode, ph_write, me.cyc, me.kind);
          end
        end
      end else if (eq.size() > 0 && eq[0].cyc <= cyc) begin
        nvec++; nbad++;
        me = eq.pop_front();
        $display("FAIL strobe_missing cyc=%0d got none want cyc=%0d kind=%0d", cyc, me.cyc, me.kind);
      end
    end
  end

  task automatic chk(string nm, int got, int want);
    nvec++;
    if (got != want) begin
      nbad++; $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Called at posedge+1: apply inputs for this cycle, predict, advance.
  task automatic drive(bit r, bit s, bit h, bit f);
    run_req = r; step_req = s; halt_req = h; finish = f;
    model_step(cyc);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    mon_en = 0; nrst = 0;
    run_req = 0; step_req = 0; halt_req = 0; finish = 0;
    sq.delete(); eq.delete();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1;
    model_reset();
    push_status(cyc);
    mon_en = 1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  bit fin_hold;
  int guard;

  initial begin
    run_req = 0; step_req = 0; halt_req = 0; finish = 0;
    div_value = 16'd4; bp_enable = 0; bp_addr = 11'd5; pc = '0;

    // Reset values.
    do_reset();
    chk("reset_outputs", int'({ph_read, ph_decode, ph_write, ram_wre, running, done, bp_hit}), 0);
    chk("reset_icount", int'(instr_count), 0);

    // Run with N=4, finish seen at the 3rd boundary.
    div_value = 16'd4; fin_hold = 0;
    drive(1, 0, 0, 0);
    chk("t1_running", int'(running), 1);
    for (int i = 0; i < 200 && !m_done; i++) begin
      if (m_act && m_ph == 2 && m_next == cyc && m_ic == 2) fin_hold = 1;
      drive(0, 0, 0, fin_hold);
    end
    repeat (20) drive(0, 0, 0, fin_hold);
    chk("t1_done", int'(done), 1);
    chk("t1_icount", int'(instr_count), 3);

    // Single step, N=1.
    do_reset();
    div_value = 16'd1;
    drive(0, 1, 0, 0);
    repeat (8) drive(0, 0, 0, 0);
    chk("t2_icount", int'(instr_count), 1);
    chk("t2_running", int'(running), 0);

    // Halt between read and decode still completes the instruction.
    do_reset();
    div_value = 16'd3;
    drive(1, 0, 0, 0);
    guard = 0;
    while (!(m_act && m_ph == 1) && guard < 50) begin drive(0, 0, 0, 0); guard++; end
    chk("t3_reach_decode", int'(guard < 50), 1);
    drive(0, 0, 1, 0);
    repeat (30) drive(0, 0, 0, 0);
    chk("t3_running", int'(running), 0);
    chk("t3_icount", int'(instr_count), 1);

    // Breakpoint at pc=5: the first boundary is skipped, the second traps.
    do_reset();
    div_value = 16'd2; bp_enable = 1; bp_addr = 11'd5; pc = 11'd5;
    drive(1, 0, 0, 0);
    repeat (30) drive(0, 0, 0, 0);
    chk("t4_bp_hit", int'(bp_hit), 1);
    chk("t4_icount", int'(instr_count), 2);
    drive(1, 0, 0, 0);
    chk("t4_bp_clear", int'(bp_hit), 0);
    repeat (30) drive(0, 0, 0, 0);
    chk("t4_bp_again", int'(bp_hit), 1);
    chk("t4_icount2", int'(instr_count), 4);
    bp_enable = 0;

    // Divider edges: run+halt together is dropped; 0 acts as 1; mid-period change.
    do_reset();
    div_value = 16'd0;
    drive(1, 0, 1, 0);
    chk("t5_run_halt_idle", int'(running), 0);
    drive(1, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    div_value = 16'd2;
    repeat (10) drive(0, 0, 0, 0);
    div_value = 16'd5;
    drive(0, 0, 0, 0);
    div_value = 16'd1;
    repeat (20) drive(0, 0, 0, 0);

    // Asynchronous reset in the cycle before ph_write.
    do_reset();
    div_value = 16'd3;
    drive(1, 0, 0, 0);
    guard = 0;
    while (!(m_act && m_ph == 2 && m_next == cyc + 1 && m_ic == 1) && guard < 100) begin
      drive(0, 0, 0, 0); guard++;
    end
    chk("t6_reach_write", int'(guard < 100), 1);
    run_req = 0; step_req = 0; halt_req = 0; finish = 0;
    @(negedge clk); #1;
    mon_en = 0; nrst = 0; sq.delete(); eq.delete();
    #1;
    chk("t6_async_outputs", int'({ph_read, ph_decode, ph_write, ram_wre, running, done, bp_hit}), 0);
    chk("t6_async_icount", int'(instr_count), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t6_no_write", int'({ph_write, ram_wre, running}), 0);
    end
    nrst = 1; model_reset(); push_status(cyc); mon_en = 1;
    repeat (10) drive(0, 0, 0, 0);
    chk("t6_after_release", int'({ph_write, running, done}), 0);

    // Randomized episodes.
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      div_value = 16'($urandom_range(0, 5));
      bp_enable = 1'($urandom_range(0, 1));
      bp_addr   = 11'($urandom_range(0, 7));
      for (int i = 0; i < 500; i++) begin
        pc = 11'($urandom_range(0, 7));
        if ($urandom_range(0, 49) == 0) div_value = 16'($urandom_range(0, 5));
        drive($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0);
      end
    end

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
